// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger scheduler for three ultrasonic sensor controllers with
// per-sensor timeout, fail-safe obstacle latching and a one-shot front-sensor priority slot.
module ultrasonic_scheduler #(
    parameter int GAP_CYCLES     = 3_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       priority_req,
    output logic [2:0] start_us,
    input  logic [2:0] us_valid,
    input  logic [8:0] obst_in,
    output logic [8:0] obst_out,
    output logic [2:0] obst_fresh,
    output logic [2:0] timeout_flag,
    output logic       busy,
    output logic       scan_done
);

    localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t        state_reg;
    logic [1:0]    sel_reg;
    logic [1:0]    resume_reg;
    logic          pending_reg;
    logic          prio_active_reg;
    logic [TW-1:0] timer_reg;

    logic [2:0] sel_hot;
    logic       sel_valid;
    logic [2:0] obst_slice;
    logic [1:0] rr_next;
    logic [1:0] sel_next;
    logic [1:0] resume_next;
    logic       prio_next;

    function automatic logic [2:0] onehot(input logic [1:0] s);
        onehot = 3'b001 << s;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sel
            assign sel_hot[gi] = (sel_reg == 2'(gi));
        end
    endgenerate

    // Only the currently selected sensor may complete a measurement.
    assign sel_valid  = |(us_valid & sel_hot);
    assign obst_slice = obst_in[3*sel_reg +: 3];

    // A priority slot jumps to sensor 0 and remembers where the rotation left off;
    // back-to-back priority slots keep the original resume point.
    always_comb begin
        rr_next     = (sel_reg == 2'd2) ? 2'd0 : sel_reg + 2'd1;
        sel_next    = rr_next;
        resume_next = resume_reg;
        prio_next   = 1'b0;
        if (pending_reg) begin
            sel_next  = 2'd0;
            prio_next = 1'b1;
            if (!prio_active_reg) begin
                resume_next = rr_next;
            end
        end else if (prio_active_reg) begin
            sel_next = resume_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            sel_reg         <= 2'd0;
            resume_reg      <= 2'd0;
            pending_reg     <= 1'b0;
            prio_active_reg <= 1'b0;
            timer_reg       <= '0;
            start_us        <= 3'b000;
            obst_fresh      <= 3'b000;
            scan_done       <= 1'b0;
            busy            <= 1'b0;
            timeout_flag    <= 3'b000;
            obst_out        <= 9'h1FF;
        end else begin
            start_us   <= 3'b000;
            obst_fresh <= 3'b000;
            scan_done  <= 1'b0;
            if (priority_req) begin
                pending_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= START;
                        busy      <= 1'b1;
                        start_us  <= sel_hot;
                    end
                end
                START: begin
                    timer_reg <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (sel_valid) begin
                        obst_out[3*sel_reg +: 3] <= obst_slice;
                        obst_fresh   <= sel_hot;
                        timeout_flag <= timeout_flag & ~sel_hot;
                        scan_done    <= (sel_reg == 2'd2);
                        timer_reg    <= '0;
                        state_reg    <= GAP;
                    end else if (timer_reg == TIMEOUT_LAST) begin
                        // No answer: assume an obstacle so the consumer stays safe.
                        obst_out[3*sel_reg +: 3] <= 3'b111;
                        timeout_flag <= timeout_flag | sel_hot;
                        scan_done    <= (sel_reg == 2'd2);
                        timer_reg    <= '0;
                        state_reg    <= GAP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (timer_reg == GAP_LAST) begin
                        sel_reg         <= sel_next;
                        resume_reg      <= resume_next;
                        prio_active_reg <= prio_next;
                        timer_reg       <= '0;
                        if (pending_reg) begin
                            pending_reg <= priority_req;
                        end
                        if (enable) begin
                            state_reg <= START;
                            start_us  <= onehot(sel_next);
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Scoreboard bench for ultrasonic_scheduler: a sensor responder model drives us_valid,
// expected start/fresh events are queued by each scenario and checked by a monitor.
module tb_ultrasonic_scheduler;

    localparam int GAP = 4;
    localparam int TMO = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       priority_req = 1'b0;
    logic [2:0] us_valid = 3'b000;
    logic [8:0] obst_in = 9'h000;
    logic [2:0] start_us;
    logic [8:0] obst_out;
    logic [2:0] obst_fresh;
    logic [2:0] timeout_flag;
    logic       busy;
    logic       scan_done;

    always #5 clk = ~clk;

    ultrasonic_scheduler #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .priority_req(priority_req),
        .start_us    (start_us),
        .us_valid    (us_valid),
        .obst_in     (obst_in),
        .obst_out    (obst_out),
        .obst_fresh  (obst_fresh),
        .timeout_flag(timeout_flag),
        .busy        (busy),
        .scan_done   (scan_done)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] data;
    } fresh_t;

    logic [1:0] start_q[$];
    fresh_t     fresh_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         done_count = 0;
    logic [1:0] last_start = 2'd0;

    logic [2:0] resp_en = 3'b000;
    logic       spur_en = 1'b0;
    int         resp_delay[3] = '{3, 3, 3};
    int         cnt[3] = '{0, 0, 0};

    function automatic logic [2:0] oh(input logic [1:0] i);
        oh = 3'b001 << i;
    endfunction

    // Sensor model: answers resp_delay cycles after its start pulse; optional stray valid on sensor 2.
    always @(negedge clk) begin
        us_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (cnt[i] > 0) begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 0) us_valid[i] = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (start_us[i] && resp_en[i]) cnt[i] = resp_delay[i];
        end
        if (start_us[0] && spur_en) cnt[2] = 2;
    end

    task automatic push_fresh(input logic [1:0] idx, input logic [2:0] data);
        fresh_t f;
        f.idx  = idx;
        f.data = data;
        fresh_q.push_back(f);
    endtask

    task automatic monitor();
        logic [1:0] ei;
        fresh_t     ef;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (start_us != 3'b000) begin
                    vectors++;
                    if (start_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL start_order: start_us=%b but no start expected", start_us);
                    end else begin
                        ei = start_q.pop_front();
                        if (start_us !== oh(ei)) begin
                            miscompares++;
                            $display("FAIL start_order: start_us=%b expected %b", start_us, oh(ei));
                        end
                    end
                    last_start = start_us[2] ? 2'd2 : (start_us[1] ? 2'd1 : 2'd0);
                end
                if (obst_fresh != 3'b000) begin
                    vectors++;
                    if (fresh_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL fresh: obst_fresh=%b but no update expected", obst_fresh);
                    end else begin
                        ef = fresh_q.pop_front();
                        if (obst_fresh !== oh(ef.idx) || obst_out[3*ef.idx +: 3] !== ef.data) begin
                            miscompares++;
                            $display("FAIL fresh: obst_fresh=%b slice=%o expected %b slice=%o",
                                     obst_fresh, obst_out[3*ef.idx +: 3], oh(ef.idx), ef.data);
                        end
                        vectors++;
                        if (scan_done !== (ef.idx == 2'd2)) begin
                            miscompares++;
                            $display("FAIL scan_done_align: scan_done=%b for sensor %0d", scan_done, ef.idx);
                        end
                    end
                end
                if (scan_done) begin
                    done_count++;
                    vectors++;
                    if (last_start !== 2'd2) begin
                        miscompares++;
                        $display("FAIL scan_done_src: pulsed after sensor %0d expected 2", last_start);
                    end
                end
            end
        end
    endtask

    task automatic wait_start(input logic [2:0] pat, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (start_us === pat) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_drain(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (start_q.size() == 0) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        priority_req = 1'b0;
        resp_en = 3'b000;
        spur_en = 1'b0;
        resp_delay = '{3, 3, 3};
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if (obst_out !== 9'h1FF) begin miscompares++; $display("FAIL reset_obst_out: got %h expected 1ff", obst_out); end
        vectors++;
        if (start_us !== 3'b000) begin miscompares++; $display("FAIL reset_start_us: got %b expected 000", start_us); end
        vectors++;
        if (obst_fresh !== 3'b000) begin miscompares++; $display("FAIL reset_obst_fresh: got %b expected 000", obst_fresh); end
        vectors++;
        if (timeout_flag !== 3'b000) begin miscompares++; $display("FAIL reset_timeout_flag: got %b expected 000", timeout_flag); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (scan_done !== 1'b0) begin miscompares++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
        $display("test_reset: done");
    endtask

    task automatic test_round_robin();
        int c;
        int d0;
        do_reset();
        obst_in = 9'o123;
        resp_en = 3'b111;
        start_q = '{2'd0, 2'd1, 2'd2, 2'd0};
        push_fresh(2'd0, 3'd3);
        push_fresh(2'd1, 3'd2);
        push_fresh(2'd2, 3'd1);
        push_fresh(2'd0, 3'd3);
        d0 = done_count;
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (start_us !== 3'b001) begin miscompares++; $display("FAIL rr_latency: start_us=%b expected 001", start_us); end
        wait_drain(c);
        vectors++;
        if (c < 0) begin miscompares++; $display("FAIL rr_starts: %0d starts still pending, expected 0", start_q.size()); end
        enable = 1'b0;
        wait_idle(c);
        vectors++;
        if (c < 0) begin miscompares++; $display("FAIL rr_idle: busy=%b expected 0", busy); end
        vectors++;
        if (done_count - d0 != 1) begin miscompares++; $display("FAIL rr_scan_done: %0d pulses expected 1", done_count - d0); end
        vectors++;
        if (obst_out !== 9'o123) begin miscompares++; $display("FAIL rr_obst_out: got %o expected 123", obst_out); end
        vectors++;
        if (fresh_q.size() != 0 || timeout_flag !== 3'b000) begin
            miscompares++;
            $display("FAIL rr_fresh: %0d updates missing, timeout_flag=%b expected 0 and 000", fresh_q.size(), timeout_flag);
        end
        $display("test_round_robin: done");
    endtask

    task automatic test_timeout();
        int c;
        int tc;
        do_reset();
        obst_in = 9'o456;
        resp_en = 3'b111;
        start_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        push_fresh(2'd0, 3'd6);
        push_fresh(2'd1, 3'd5);
        push_fresh(2'd2, 3'd4);
        push_fresh(2'd0, 3'd6);
        push_fresh(2'd2, 3'd4);
        push_fresh(2'd0, 3'd6);
        push_fresh(2'd1, 3'd5);
        enable = 1'b1;
        wait_start(3'b010, c);
        @(negedge clk);
        resp_en = 3'b101;
        wait_start(3'b010, c);
        tc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (timeout_flag === 3'b010) begin
                tc = k;
                break;
            end
        end
        vectors++;
        if (tc != TMO + 1) begin miscompares++; $display("FAIL to_latency: flag after %0d cycles expected %0d", tc, TMO + 1); end
        vectors++;
        if (obst_out[5:3] !== 3'b111 || obst_out[2:0] !== 3'd6) begin
            miscompares++;
            $display("FAIL to_failsafe: obst_out=%o expected x76", obst_out);
        end
        resp_en = 3'b111;
        wait_drain(c);
        vectors++;
        if (c < 0) begin miscompares++; $display("FAIL to_starts: %0d starts pending expected 0", start_q.size()); end
        enable = 1'b0;
        wait_idle(c);
        vectors++;
        if (timeout_flag !== 3'b000) begin miscompares++; $display("FAIL to_flag_clear: got %b expected 000", timeout_flag); end
        vectors++;
        if (obst_out !== 9'o456 || fresh_q.size() != 0) begin
            miscompares++;
            $display("FAIL to_recover: obst_out=%o pending=%0d expected 456 and 0", obst_out, fresh_q.size());
        end
        $display("test_timeout: done");
    endtask

    task automatic test_priority();
        int c;
        do_reset();
        obst_in = 9'o315;
        resp_en = 3'b111;
        start_q = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
        push_fresh(2'd0, 3'd5);
        push_fresh(2'd1, 3'd1);
        push_fresh(2'd0, 3'd5);
        push_fresh(2'd2, 3'd3);
        push_fresh(2'd0, 3'd5);
        enable = 1'b1;
        wait_start(3'b010, c);
        @(negedge clk);
        priority_req = 1'b1;
        @(negedge clk);
        priority_req = 1'b0;
        @(negedge clk);
        priority_req = 1'b1;
        @(negedge clk);
        priority_req = 1'b0;
        wait_drain(c);
        vectors++;
        if (c < 0) begin miscompares++; $display("FAIL prio_starts: %0d starts pending expected 0", start_q.size()); end
        enable = 1'b0;
        wait_idle(c);
        vectors++;
        if (c < 0 || fresh_q.size() != 0) begin
            miscompares++;
            $display("FAIL prio_complete: busy=%b pending=%0d expected 0 and 0", busy, fresh_q.size());
        end
        vectors++;
        if (obst_out !== 9'o315) begin miscompares++; $display("FAIL prio_obst_out: got %o expected 315", obst_out); end
        $display("test_priority: done");
    endtask

    task automatic test_ignore_and_tie();
        int c;
        int fc;
        do_reset();
        obst_in = 9'o052;
        resp_en = 3'b001;
        resp_delay = '{TMO, 3, 3};
        spur_en = 1'b1;
        start_q = '{2'd0};
        push_fresh(2'd0, 3'd2);
        enable = 1'b1;
        wait_start(3'b001, c);
        @(negedge clk);
        enable = 1'b0;
        fc = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (obst_fresh !== 3'b000) begin
                fc = k;
                break;
            end
        end
        vectors++;
        if (fc != TMO + 1) begin miscompares++; $display("FAIL tie_valid_wins: fresh after %0d cycles expected %0d", fc, TMO + 1); end
        vectors++;
        if (timeout_flag !== 3'b000) begin miscompares++; $display("FAIL tie_flag: got %b expected 000", timeout_flag); end
        vectors++;
        if (obst_out !== 9'o772) begin miscompares++; $display("FAIL ignore_other: obst_out=%o expected 772", obst_out); end
        wait_idle(c);
        vectors++;
        if (c != GAP) begin miscompares++; $display("FAIL stop_after_gap: idle after %0d cycles expected %0d", c, GAP); end
        repeat (12) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || start_q.size() != 0 || fresh_q.size() != 0) begin
            miscompares++;
            $display("FAIL stop_idle: busy=%b starts=%0d fresh=%0d expected 0", busy, start_q.size(), fresh_q.size());
        end
        resp_delay = '{3, 3, 3};
        spur_en = 1'b0;
        $display("test_ignore_and_tie: done");
    endtask

    task automatic test_reset_mid_wait();
        int c;
        // Continues from the previous scenario: sel has advanced to sensor 1, obst_out holds 772.
        obst_in = 9'o052;
        resp_en = 3'b010;
        start_q = '{2'd1};
        enable = 1'b1;
        wait_start(3'b010, c);
        vectors++;
        if (c < 0) begin miscompares++; $display("FAIL rst_start: no start seen, expected 010"); end
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (obst_out !== 9'h1FF) begin miscompares++; $display("FAIL rst_obst_out: got %h expected 1ff", obst_out); end
        vectors++;
        if ({start_us, obst_fresh, timeout_flag, busy, scan_done} !== 11'd0) begin
            miscompares++;
            $display("FAIL rst_outputs: start=%b fresh=%b flag=%b busy=%b done=%b expected all 0",
                     start_us, obst_fresh, timeout_flag, busy, scan_done);
        end
        reset = 1'b0;
        enable = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || start_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_quiet: busy=%b starts=%0d expected 0", busy, start_q.size());
        end
        $display("test_reset_mid_wait: done");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_round_robin();
        test_timeout();
        test_priority();
        test_ignore_and_tie();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
